memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
// - Memory stage between execute and write_back_fetch; owns the 16-bit data-memory bus.
// - Splits each load/store into 1 (byte/halfword) or 2 (word: low half, then high half) bus beats.
// - Assembles and extends load data; stalls upstream while beats are pending.
// - Non-memory results pass through with 1-cycle latency.
// PARAMETERS
// - ADDR_W  32  data-memory address width (bytes)
// - RD_W    4   destination register index width
// PORTS
// - clk_i            in   1       clock
// - rst_i            in   1       asynchronous reset, active-high
// - ex_valid_i       in   1       execute presents an op this cycle
// - ex_result_i      in   32      ALU result: address for mem ops, value otherwise
// - ex_store_data_i  in   32      store data
// - ex_mem_read_i    in   1       load
// - ex_mem_write_i   in   1       store
// - ex_size_i        in   2       00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
// - ex_signed_i      in   1       sign-extend byte/halfword loads
// - ex_rd_i          in   RD_W    destination register
// - ex_reg_write_i   in   1       op writes rd
// - stall_o          out  1       hold execute; op not accepted
// - dmem_addr_o      out  ADDR_W  bus address (halfword granule)
// - dmem_wdata_o     out  16      bus write data
// - dmem_be_o        out  2       byte enables {hi,lo}
// - dmem_re_o        out  1       read strobe
// - dmem_we_o        out  1       write strobe
// - dmem_rdata_i     in   16      read data, valid when dmem_ready_i=1
// - dmem_ready_i     in   1       beat completes this cycle
// - wb_valid_o       out  1       result valid for write-back (1-cycle pulse)
// - wb_data_o        out  32      result / load data
// - wb_rd_o          out  RD_W    destination register
// - wb_reg_write_o   out  1       write enable for rd
// - misalign_o       out  1       misaligned access flagged (0 unless trap enabled)
// BEHAVIOUR
// - Reset (async): state IDLE; all outputs 0; any in-flight beat abandoned, re/we drop at once.
// - FSM: IDLE, LOW, HIGH. stall_o = (state != IDLE). Accepts op when ex_valid_i && state==IDLE.
// - Non-mem op accepted: next edge wb_valid_o=1, wb_data_o=ex_result_i, rd/reg_write copied.
// - Mem op accepted: latch op, go LOW. Read and write both set: read wins, write ignored.
// - LOW: addr = {a[31:1],0}; re/we asserted until dmem_ready_i. On ready: word -> HIGH, else
//   finish. Load low half captured on ready.
// - HIGH: addr = low addr + 2, be=11; on ready capture high half, finish.
// - Finish: return IDLE; next cycle wb_valid_o=1 with assembled data; can accept new op in IDLE.
// - Byte: be = a[0] ? 10 : 01; load picks lane, extends per ex_signed_i; store replicates byte
//   in both lanes. Halfword: be=11, extend to 32. Word: {hi,lo}, no extension.
// - Store: wb_valid_o pulses on completion with wb_reg_write_o=0.
// - dmem_ready_i ignored in IDLE. No timeout; beat waits indefinitely.
// - Latency: pass-through 1; halfword load, zero-wait memory 2; word load 3.
// - Address add for HIGH is 32-bit modulo (0xFFFF_FFFE + 2 wraps to 0).
// CONFIGURATION
// - MISALIGN_TRAP_EN defined: halfword/word with a[0]=1 issues no bus beat; next edge
//   wb_valid_o=1, wb_reg_write_o=0, misalign_o=1 for that cycle.
// - Not defined: a[0] forced 0 for halfword/word; misalign_o tied 0.
// STRUCTURE
// - mem_pkg: mem_size_e (BYTE/HALF/WORD/RSVD), ma_state_e (IDLE/LOW/HIGH), BE_LO/BE_HI/BE_ALL.
// - Sub-module load_align: combinational lane select + sign/zero extend.
// TESTING
// - Pass-through: ex_result_i=0x1234_5678, reg_write=1 -> next cycle wb_valid_o, wb_data_o=0x1234_5678.
// - Word load @0x100, mem 0x100=0xBEEF, 0x102=0xDEAD, zero-wait -> beats 0x100,0x102;
//   wb_data_o=0xDEAD_BEEF; stall_o high 2 cycles.
// - Signed byte load @0x101, rdata=0x8011 -> be=10, wb_data_o=0xFFFF_FF80; unsigned -> 0x80.
// - Word store 0xCAFE_F00D @0x200, ready delayed 3 cycles per beat -> wdata 0xF00D then 0xCAFE,
//   we held until ready, wb_reg_write_o=0.
// - rst_i asserted in HIGH -> re/we, stall_o, wb_valid_o drop immediately; state IDLE.
// - Halfword load @0x301: with MISALIGN_TRAP_EN misalign_o=1, no beat; without, beat at 0x300.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and byte-enable constants for the memory-access stage.
package mem_pkg;
    typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, RSVD = 2'b11} mem_size_e;
    typedef enum logic [1:0] {IDLE, LOW, HIGH} ma_state_e;
    localparam logic [1:0] BE_LO  = 2'b01;
    localparam logic [1:0] BE_HI  = 2'b10;
    localparam logic [1:0] BE_ALL = 2'b11;
endpackage

// File: rtl/load_align.sv
// load_align: picks the byte lane of a 16-bit beat and sign/zero-extends byte or halfword loads.
module load_align
    import mem_pkg::*;
(
    input  logic [15:0] rdata_i,
    input  logic        lane_i,
    input  mem_size_e   size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);
    logic [7:0] b;
    assign b = lane_i ? rdata_i[15:8] : rdata_i[7:0];
    always_comb data_o = size_i == BYTE ? {{24{signed_i & b[7]}}, b}
                                        : {{16{signed_i & rdata_i[15]}}, rdata_i};
endmodule

// File: rtl/memory_access.sv
// memory_access: memory stage splitting loads/stores into 16-bit bus beats (word = low then high half).
// Define MISALIGN_TRAP_EN to make misaligned halfword/word ops complete without a beat and raise misalign_o.
module memory_access
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    input  logic [31:0]       ex_result_i,
    input  logic [31:0]       ex_store_data_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_mem_write_i,
    input  logic [1:0]        ex_size_i,
    input  logic              ex_signed_i,
    input  logic [RD_W-1:0]   ex_rd_i,
    input  logic              ex_reg_write_i,
    output logic              stall_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [15:0]       dmem_wdata_o,
    output logic [1:0]        dmem_be_o,
    output logic              dmem_re_o,
    output logic              dmem_we_o,
    input  logic [15:0]       dmem_rdata_i,
    input  logic              dmem_ready_i,
    output logic              wb_valid_o,
    output logic [31:0]       wb_data_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic              wb_reg_write_o,
    output logic              misalign_o
);
`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    ma_state_e         state_q, state_d;
    mem_size_e         size_q, size_d;
    logic              lane_q, lane_d, sgn_q, sgn_d, rw_q, rw_d, wr_q, wr_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [15:0]       st_hi_q, st_hi_d, lo_q, lo_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [15:0]       dmem_wdata_q, dmem_wdata_d;
    logic [1:0]        dmem_be_q, dmem_be_d;
    logic              dmem_re_q, dmem_re_d, dmem_we_q, dmem_we_d;
    logic              wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, misalign_q, misalign_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;

    logic [ADDR_W-1:0] ex_addr;
    mem_size_e         ex_size;
    logic              ex_mem, ex_misalign, is_word, finish;
    logic [31:0]       ld_data, fin_data;

    assign ex_addr     = ex_result_i[ADDR_W-1:0];
    assign ex_size     = mem_size_e'(ex_size_i);
    assign ex_mem      = ex_mem_read_i | ex_mem_write_i;
    assign ex_misalign = TRAP && ex_size != BYTE && ex_addr[0];
    assign is_word     = size_q == WORD || size_q == RSVD;
    assign finish      = dmem_ready_i && (state_q == HIGH || (state_q == LOW && !is_word));
    assign fin_data    = wr_q ? '0 : state_q == HIGH ? {dmem_rdata_i, lo_q} : ld_data;

    load_align u_load_align (
        .rdata_i  (dmem_rdata_i),
        .lane_i   (lane_q),
        .size_i   (size_q),
        .signed_i (sgn_q),
        .data_o   (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        lane_d       = lane_q;
        sgn_d        = sgn_q;
        rw_d         = rw_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        st_hi_d      = st_hi_q;
        lo_d         = lo_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        dmem_re_d    = dmem_re_q;
        dmem_we_d    = dmem_we_q;
        wb_valid_d   = 1'b0;
        wb_data_d    = '0;
        wb_rd_d      = '0;
        wb_rw_d      = 1'b0;
        misalign_d   = 1'b0;
        case (state_q)
            IDLE: if (ex_valid_i) begin
                wb_rd_d = ex_rd_i;
                if (!ex_mem || ex_misalign) begin
                    // pass-through result, or a trapped misaligned access that never reaches the bus
                    wb_valid_d = 1'b1;
                    wb_data_d  = ex_mem ? '0 : ex_result_i;
                    wb_rw_d    = ex_reg_write_i & ~ex_mem;
                    misalign_d = ex_mem;
                end else begin
                    state_d      = LOW;
                    size_d       = ex_size;
                    lane_d       = ex_size == BYTE && ex_addr[0];
                    sgn_d        = ex_signed_i;
                    rd_d         = ex_rd_i;
                    wr_d         = ~ex_mem_read_i;
                    rw_d         = ex_reg_write_i & ex_mem_read_i;
                    st_hi_d      = ex_store_data_i[31:16];
                    dmem_addr_d  = {ex_addr[ADDR_W-1:1], 1'b0};
                    dmem_be_d    = ex_size != BYTE ? BE_ALL : ex_addr[0] ? BE_HI : BE_LO;
                    dmem_wdata_d = ex_size == BYTE ? {2{ex_store_data_i[7:0]}} : ex_store_data_i[15:0];
                    dmem_re_d    = ex_mem_read_i;
                    dmem_we_d    = ~ex_mem_read_i;
                end
            end
            LOW: if (dmem_ready_i && is_word) begin
                state_d      = HIGH;
                lo_d         = dmem_rdata_i;
                dmem_addr_d  = dmem_addr_q + ADDR_W'(2);
                dmem_be_d    = BE_ALL;
                dmem_wdata_d = st_hi_q;
            end
            HIGH: ;
            default: state_d = IDLE;
        endcase
        if (finish) begin
            state_d      = IDLE;
            dmem_addr_d  = '0;
            dmem_wdata_d = '0;
            dmem_be_d    = '0;
            dmem_re_d    = 1'b0;
            dmem_we_d    = 1'b0;
            wb_valid_d   = 1'b1;
            wb_data_d    = fin_data;
            wb_rd_d      = rd_q;
            wb_rw_d      = rw_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            size_q       <= BYTE;
            lane_q       <= 1'b0;
            sgn_q        <= 1'b0;
            rw_q         <= 1'b0;
            wr_q         <= 1'b0;
            rd_q         <= '0;
            st_hi_q      <= '0;
            lo_q         <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            dmem_re_q    <= 1'b0;
            dmem_we_q    <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_rd_q      <= '0;
            wb_rw_q      <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            sgn_q        <= sgn_d;
            rw_q         <= rw_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            st_hi_q      <= st_hi_d;
            lo_q         <= lo_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            dmem_re_q    <= dmem_re_d;
            dmem_we_q    <= dmem_we_d;
            wb_valid_q   <= wb_valid_d;
            wb_data_q    <= wb_data_d;
            wb_rd_q      <= wb_rd_d;
            wb_rw_q      <= wb_rw_d;
            misalign_q   <= misalign_d;
        end
    end

    assign stall_o        = state_q != IDLE;
    assign dmem_addr_o    = dmem_addr_q;
    assign dmem_wdata_o   = dmem_wdata_q;
    assign dmem_be_o      = dmem_be_q;
    assign dmem_re_o      = dmem_re_q;
    assign dmem_we_o      = dmem_we_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_data_o      = wb_data_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_reg_write_o = wb_rw_q;
    assign misalign_o     = misalign_q;
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vector table, hand sequences and random ops against a byte-level memory model.
module tb_memory_access;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk_i = 0, rst_i = 0;
    logic        ex_valid_i = 0, ex_mem_read_i = 0, ex_mem_write_i = 0, ex_signed_i = 0, ex_reg_write_i = 0;
    logic [31:0] ex_result_i = 0, ex_store_data_i = 0;
    logic [1:0]  ex_size_i = 0;
    logic [3:0]  ex_rd_i = 0;
    logic        stall_o, dmem_re_o, dmem_we_o, wb_valid_o, wb_reg_write_o, misalign_o;
    logic [31:0] dmem_addr_o, wb_data_o;
    logic [15:0] dmem_wdata_o;
    logic [15:0] dmem_rdata_i = 0;
    logic        dmem_ready_i = 0;
    logic [1:0]  dmem_be_o;
    logic [3:0]  wb_rd_o;

    memory_access #(.ADDR_W(32), .RD_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i),
        .ex_store_data_i(ex_store_data_i), .ex_mem_read_i(ex_mem_read_i), .ex_mem_write_i(ex_mem_write_i),
        .ex_size_i(ex_size_i), .ex_signed_i(ex_signed_i), .ex_rd_i(ex_rd_i), .ex_reg_write_i(ex_reg_write_i),
        .stall_o(stall_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_re_o(dmem_re_o), .dmem_we_o(dmem_we_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ready_i(dmem_ready_i),
        .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_reg_write_o(wb_reg_write_o),
        .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  be;
        logic        we;
        logic [15:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic        rw;
        logic        pre;
        logic [31:0] pre_a;
        logic [15:0] pre_v;
        logic [31:0] exp_data;
        logic        exp_rw;
        int          exp_lat;
        int          exp_beats;
        logic [31:0] exp_a0;
        logic [1:0]  exp_be0;
    } vec_t;

    logic [15:0] dev [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    beat_t       beats[$];
    int          mem_lat = 0, glitches = 0;
    int          errs = 0, checks = 0;

    function automatic logic [15:0] dev_rd(input logic [31:0] a);
        return dev.exists(a) ? dev[a] : 16'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory device: holds each beat for mem_lat cycles, then completes it and logs it.
    task automatic responder();
        int cnt = 0;
        logic waiting = 0, pre = 0, pwe = 0;
        logic [31:0] pa = 0;
        logic [15:0] h;
        forever begin
            @(negedge clk_i);
            if (rst_i || !(dmem_re_o || dmem_we_o)) begin
                dmem_ready_i = 0; cnt = 0; waiting = 0;
            end else begin
                if (waiting && (dmem_addr_o != pa || dmem_re_o != pre || dmem_we_o != pwe)) glitches++;
                if (cnt >= mem_lat) begin
                    dmem_ready_i = 1;
                    dmem_rdata_i = dev_rd(dmem_addr_o);
                    if (dmem_we_o) begin
                        h = dev_rd(dmem_addr_o);
                        if (dmem_be_o[0]) h[7:0] = dmem_wdata_o[7:0];
                        if (dmem_be_o[1]) h[15:8] = dmem_wdata_o[15:8];
                        dev[dmem_addr_o] = h;
                    end
                    beats.push_back('{dmem_addr_o, dmem_be_o, dmem_we_o, dmem_wdata_o});
                    cnt = 0; waiting = 0;
                end else begin
                    dmem_ready_i = 0; cnt++; waiting = 1;
                    pa = dmem_addr_o; pre = dmem_re_o; pwe = dmem_we_o;
                end
            end
        end
    endtask

    task automatic do_op(input logic [31:0] res, input logic [31:0] sd, input logic rd_en, input logic wr_en,
                         input logic [1:0] sz, input logic sg, input logic [3:0] rd, input logic rw, input int lat_cfg,
                         output logic [31:0] d, output logic o_rw, output logic o_mis, output logic [3:0] o_rd,
                         output int lat, output int stalls);
        mem_lat = lat_cfg;
        beats.delete();
        ex_result_i = res; ex_store_data_i = sd; ex_mem_read_i = rd_en; ex_mem_write_i = wr_en;
        ex_size_i = sz; ex_signed_i = sg; ex_rd_i = rd; ex_reg_write_i = rw; ex_valid_i = 1;
        @(posedge clk_i); #1;
        ex_valid_i = 0; ex_mem_read_i = 0; ex_mem_write_i = 0;
        lat = 0; stalls = 0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk_i);
            lat++;
            if (stall_o) stalls++;
            if (wb_valid_o) break;
        end
        chk("wb_valid_seen", {31'b0, wb_valid_o}, 32'd1);
        d = wb_data_o; o_rw = wb_reg_write_o; o_mis = misalign_o; o_rd = wb_rd_o;
        @(posedge clk_i); #1;
    endtask

    // Byte-addressed little-endian model of what a load should return.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [31:0] aa;
        int unsigned v;
        aa = sz == 2'd0 ? a : (a & ~32'd1);
        if (sz == 2'd0) begin
            v = ref_mem[aa];
            if (sg && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = ref_mem[aa] + 256 * ref_mem[aa + 1];
            if (sg && v >= 32768) v = v - 65536;
        end else begin
            v = ref_mem[aa] + 256 * ref_mem[aa + 1] + 65536 * ref_mem[aa + 2] + 16777216 * ref_mem[aa + 3];
        end
        return v;
    endfunction

    vec_t        vecs[10];
    logic [31:0] d, a, sd, aa, exp_d;
    logic        o_rw, o_mis, sg, rwv, mis, mem, ld, st;
    logic [3:0]  o_rd, rdv;
    logic [1:0]  sz;
    int          lat, stalls, kind, n_exp, found;

    initial begin
        fork responder(); join_none
        #1 rst_i = 1;
        #1;
        chk("rst_stall", {31'b0, stall_o}, 0);
        chk("rst_re_we", {30'b0, dmem_re_o, dmem_we_o}, 0);
        chk("rst_wb_valid", {31'b0, wb_valid_o}, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_misalign", {31'b0, misalign_o}, 0);
        @(posedge clk_i); @(posedge clk_i); #1 rst_i = 0;

        dev[32'h100] = 16'hBEEF; dev[32'h102] = 16'hDEAD; dev[32'h0] = 16'h2468;
        vecs[0] = '{32'h1234_5678, 0, 0, 0, 2'd2, 0, 1, 0, 0, 0, 32'h1234_5678, 1, 1, 0, 0, 0};
        vecs[1] = '{32'h100, 0, 1, 0, 2'd2, 0, 1, 0, 0, 0, 32'hDEAD_BEEF, 1, 3, 2, 32'h100, 2'b11};
        vecs[2] = '{32'h101, 0, 1, 0, 2'd0, 1, 1, 1, 32'h100, 16'h8011, 32'hFFFF_FF80, 1, 2, 1, 32'h100, 2'b10};
        vecs[3] = '{32'h101, 0, 1, 0, 2'd0, 0, 1, 0, 0, 0, 32'h0000_0080, 1, 2, 1, 32'h100, 2'b10};
        vecs[4] = '{32'h100, 0, 1, 0, 2'd0, 1, 1, 0, 0, 0, 32'h0000_0011, 1, 2, 1, 32'h100, 2'b01};
        vecs[5] = '{32'h100, 0, 1, 0, 2'd1, 1, 1, 0, 0, 0, 32'hFFFF_8011, 1, 2, 1, 32'h100, 2'b11};
        vecs[6] = '{32'h0000_A5A5, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 32'h0000_A5A5, 0, 1, 0, 0, 0};
        vecs[7] = '{32'h102, 32'hFFFF, 1, 1, 2'd1, 0, 1, 0, 0, 0, 32'h0000_DEAD, 1, 2, 1, 32'h102, 2'b11};
        vecs[8] = '{32'h100, 0, 1, 0, 2'd3, 0, 1, 0, 0, 0, 32'hDEAD_8011, 1, 3, 2, 32'h100, 2'b11};
        vecs[9] = '{32'hFFFF_FFFE, 0, 1, 0, 2'd2, 0, 1, 1, 32'hFFFF_FFFE, 16'h1357, 32'h2468_1357, 1, 3, 2, 32'hFFFF_FFFE, 2'b11};

        foreach (vecs[i]) begin
            if (vecs[i].pre) dev[vecs[i].pre_a] = vecs[i].pre_v;
            do_op(vecs[i].res, vecs[i].sd, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].sg, 4'(i), vecs[i].rw, 0,
                  d, o_rw, o_mis, o_rd, lat, stalls);
            chk($sformatf("v%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("v%0d_rw", i), {31'b0, o_rw}, {31'b0, vecs[i].exp_rw});
            chk($sformatf("v%0d_rd", i), {28'b0, o_rd}, i);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_stall", i), stalls, vecs[i].exp_lat - 1);
            chk($sformatf("v%0d_beats", i), beats.size(), vecs[i].exp_beats);
            if (beats.size() > 0) begin
                chk($sformatf("v%0d_addr0", i), beats[0].addr, vecs[i].exp_a0);
                chk($sformatf("v%0d_be0", i), {30'b0, beats[0].be}, {30'b0, vecs[i].exp_be0});
                chk($sformatf("v%0d_we0", i), {31'b0, beats[0].we}, {31'b0, vecs[i].wr & ~vecs[i].rd});
            end
            if (beats.size() > 1) chk($sformatf("v%0d_addr1", i), beats[1].addr, vecs[i].exp_a0 + 32'd2);
        end

        // Word store with three wait cycles per beat.
        glitches = 0;
        do_op(32'h200, 32'hCAFE_F00D, 0, 1, 2'd2, 0, 4'd5, 1, 3, d, o_rw, o_mis, o_rd, lat, stalls);
        chk("wst_rw", {31'b0, o_rw}, 0);
        chk("wst_lat", lat, 9);
        chk("wst_hold", glitches, 0);
        chk("wst_beats", beats.size(), 2);
        if (beats.size() == 2) begin
            chk("wst_w0", {beats[0].we, beats[0].be, 13'b0, beats[0].wdata}, {1'b1, 2'b11, 13'b0, 16'hF00D});
            chk("wst_w1", {beats[1].we, beats[1].be, 13'b0, beats[1].wdata}, {1'b1, 2'b11, 13'b0, 16'hCAFE});
            chk("wst_a1", beats[1].addr, 32'h202);
        end
        do_op(32'h200, 0, 1, 0, 2'd2, 0, 4'd6, 1, 1, d, o_rw, o_mis, o_rd, lat, stalls);
        chk("wst_readback", d, 32'hCAFE_F00D);

        // Byte store replicates the byte into both lanes, enabling only the upper one.
        do_op(32'h201, 32'h0000_005A, 0, 1, 2'd0, 0, 4'd1, 1, 0, d, o_rw, o_mis, o_rd, lat, stalls);
        chk("bst_beats", beats.size(), 1);
        if (beats.size() == 1) chk("bst_beat", {beats[0].be, 14'b0, beats[0].wdata}, {2'b10, 14'b0, 16'h5A5A});
        do_op(32'h200, 0, 1, 0, 2'd1, 0, 4'd1, 1, 0, d, o_rw, o_mis, o_rd, lat, stalls);
        chk("bst_readback", d, 32'h0000_5A0D);

        // Misaligned halfword load.
        dev[32'h300] = 16'h4321;
        do_op(32'h301, 0, 1, 0, 2'd1, 0, 4'd2, 1, 0, d, o_rw, o_mis, o_rd, lat, stalls);
        chk("mis_flag", {31'b0, o_mis}, {31'b0, TRAP});
        chk("mis_beats", beats.size(), TRAP ? 0 : 1);
        chk("mis_rw", {31'b0, o_rw}, {31'b0, ~TRAP});
        chk("mis_data", d, TRAP ? 32'h0 : 32'h4321);
        if (beats.size() > 0) chk("mis_addr", beats[0].addr, 32'h300);

        // Reset while the high beat of a word load is waiting.
        mem_lat = 5;
        ex_result_i = 32'h100; ex_mem_read_i = 1; ex_size_i = 2'd2; ex_reg_write_i = 1; ex_valid_i = 1;
        @(posedge clk_i); #1 ex_valid_i = 0; ex_mem_read_i = 0;
        found = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (dmem_addr_o == 32'h102 && dmem_re_o) begin found = 1; break; end
        end
        chk("rst_reach_high", found, 1);
        #2 rst_i = 1;
        #1;
        chk("rsth_re_we", {30'b0, dmem_re_o, dmem_we_o}, 0);
        chk("rsth_stall", {31'b0, stall_o}, 0);
        chk("rsth_wb_valid", {31'b0, wb_valid_o}, 0);
        @(posedge clk_i); #1 rst_i = 0;
        do_op(32'h0BAD_F00D, 0, 0, 0, 2'd0, 0, 4'd3, 1, 0, d, o_rw, o_mis, o_rd, lat, stalls);
        chk("rsth_after_lat", lat, 1);
        chk("rsth_after_data", d, 32'h0BAD_F00D);

        // Random ops in 0x400..0x4FF against the byte-level model.
        for (int k = 0; k < 128; k++) begin
            sd = $urandom;
            dev[32'h400 + 2 * k] = sd[15:0];
            ref_mem[32'h400 + 2 * k] = sd[7:0];
            ref_mem[32'h401 + 2 * k] = sd[15:8];
        end
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 4);
            sz = 2'($urandom_range(0, 3));
            a = 32'h400 + $urandom_range(0, 251);
            sd = $urandom;
            sg = 1'($urandom_range(0, 1));
            rwv = 1'($urandom_range(0, 1));
            rdv = 4'($urandom_range(0, 15));
            mem = kind != 0;
            ld = kind == 1 || kind == 2;
            st = kind >= 3;
            mis = TRAP && mem && sz != 2'd0 && a[0];
            n_exp = (!mem || mis) ? 0 : sz[1] ? 2 : 1;
            exp_d = ld ? ref_load(a, sz, sg) : sd;
            do_op(mem ? a : sd, sd, ld, st, sz, sg, rdv, rwv, $urandom_range(0, 2), d, o_rw, o_mis, o_rd, lat, stalls);
            chk($sformatf("r%0d_beats", t), beats.size(), n_exp);
            chk($sformatf("r%0d_mis", t), {31'b0, o_mis}, {31'b0, mis});
            chk($sformatf("r%0d_rw", t), {31'b0, o_rw}, {31'b0, rwv & (kind == 0 || (ld && !mis))});
            if (kind == 0 || (ld && !mis)) begin
                chk($sformatf("r%0d_data", t), d, exp_d);
                chk($sformatf("r%0d_rd", t), {28'b0, o_rd}, {28'b0, rdv});
            end
            if (st && !mis) begin
                aa = sz == 2'd0 ? a : (a & ~32'd1);
                for (int b = 0; b < (sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4); b++) ref_mem[aa + b] = sd[8 * b +: 8];
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
